// File: rtl/trap_controller_if.sv
// Signal bundle between the datapath/CSR side and the trap controller.
// The master side drives requests and CSR state; the slave is the controller itself.
interface trap_controller_if;
    logic        insn_boundary;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_badaddr;
    logic [31:0] int_pc;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [1:0]  privilege_mode;
    logic        exception_select;
    logic        exception_event;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] badaddr;
    logic        trap_done;
    logic        busy;
    logic        wfi_wakeup;
    logic        trap_error;

    modport master (
        output insn_boundary, exc_valid, exc_cause, exc_pc, exc_badaddr, int_pc,
               mstatus, mie, mip, privilege_mode, exception_select,
        input  exception_event, cause, pc, badaddr, trap_done, busy, wfi_wakeup, trap_error
    );

    modport slave (
        input  insn_boundary, exc_valid, exc_cause, exc_pc, exc_badaddr, int_pc,
               mstatus, mie, mip, privilege_mode, exception_select,
        output exception_event, cause, pc, badaddr, trap_done, busy, wfi_wakeup, trap_error
    );
endinterface

// File: rtl/trap_controller.sv
// Trap sequencer: arbitrates exceptions and M-mode interrupts, strobes the CSR unit,
// then waits (bounded) for the redirect before handing control back to the main FSM.
module trap_controller #(
    parameter int REDIRECT_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          resetn,
    trap_controller_if.slave bus
);
    localparam int CNT_W = $clog2(REDIRECT_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_REDIR, DONE} state_t;

    state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] badaddr_reg, badaddr_next;
    logic        trap_error_reg, trap_error_next;
    logic        wfi_reg;

    logic [31:0] pend;
    logic        int_en;
    logic [31:0] int_cause;
    logic        unused_mstatus;

    assign unused_mstatus = &{1'b0, bus.mstatus[31:4], bus.mstatus[2:0]};

    // Only MEI, MSI and MTI are serviced by this controller.
    assign pend    = bus.mie & bus.mip & 32'h0000_0888;
    assign int_en  = (bus.privilege_mode < 2'd3) || bus.mstatus[3];
    assign cnt_inc = cnt_reg + 1'b1;

    always_comb begin
        int_cause = 32'h8000_0007;
        if (pend[11])
            int_cause = 32'h8000_000B;
        else if (pend[3])
            int_cause = 32'h8000_0003;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cause_reg      <= '0;
            pc_reg         <= '0;
            badaddr_reg    <= '0;
            trap_error_reg <= 1'b0;
            wfi_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cause_reg      <= cause_next;
            pc_reg         <= pc_next;
            badaddr_reg    <= badaddr_next;
            trap_error_reg <= trap_error_next;
            wfi_reg        <= |pend;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        cause_next      = cause_reg;
        pc_next         = pc_reg;
        badaddr_next    = badaddr_reg;
        trap_error_next = trap_error_reg;
        case (state_reg)
            IDLE: begin
                // Exceptions are synchronous to the faulting instruction, so they beat interrupts.
                if (bus.exc_valid) begin
                    cause_next   = bus.exc_cause;
                    pc_next      = bus.exc_pc;
                    badaddr_next = bus.exc_badaddr;
                    cnt_next     = '0;
                    state_next   = FIRE;
                end else if (bus.insn_boundary && int_en && (pend != 32'd0)) begin
                    cause_next   = int_cause;
                    pc_next      = bus.int_pc;
                    badaddr_next = 32'd0;
                    cnt_next     = '0;
                    state_next   = FIRE;
                end
            end
            FIRE: state_next = WAIT_REDIR;
            WAIT_REDIR: begin
                if (bus.exception_select) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_W'(REDIRECT_TIMEOUT)) begin
                        trap_error_next = 1'b1;
                        state_next      = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.exception_event = (state_reg == FIRE);
    assign bus.trap_done       = (state_reg == DONE);
    assign bus.busy            = (state_reg != IDLE);
    assign bus.cause           = cause_reg;
    assign bus.pc              = pc_reg;
    assign bus.badaddr         = badaddr_reg;
    assign bus.trap_error      = trap_error_reg;
    assign bus.wfi_wakeup      = wfi_reg;
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exception, interrupt, gating, arbitration,
// redirect timeout and reset abort, each checked against hand-computed values.
module tb_trap_controller;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    trap_controller_if tif();

    trap_controller #(.REDIRECT_TIMEOUT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        tif.insn_boundary    = 1'b0;
        tif.exc_valid        = 1'b0;
        tif.exc_cause        = '0;
        tif.exc_pc           = '0;
        tif.exc_badaddr      = '0;
        tif.int_pc           = '0;
        tif.mstatus          = '0;
        tif.mie              = '0;
        tif.mip              = '0;
        tif.privilege_mode   = 2'd3;
        tif.exception_select = 1'b0;
        tick();
        tick();
        check("rst_busy",   32'(tif.busy), 32'd0);
        check("rst_event",  32'(tif.exception_event), 32'd0);
        check("rst_done",   32'(tif.trap_done), 32'd0);
        check("rst_err",    32'(tif.trap_error), 32'd0);
        check("rst_wfi",    32'(tif.wfi_wakeup), 32'd0);
        check("rst_cause",  tif.cause, 32'd0);
        check("rst_pc",     tif.pc, 32'd0);
        check("rst_bad",    tif.badaddr, 32'd0);
        resetn = 1'b1;
        tick();

        // Exception with nominal redirect in N+2
        tif.exc_valid   = 1'b1;
        tif.exc_cause   = 32'd2;
        tif.exc_pc      = 32'h8000_0100;
        tif.exc_badaddr = 32'hFFFF_FFFF;
        tick();
        tif.exc_valid = 1'b0;
        check("exc_event",  32'(tif.exception_event), 32'd1);
        check("exc_cause",  tif.cause, 32'd2);
        check("exc_pc",     tif.pc, 32'h8000_0100);
        check("exc_bad",    tif.badaddr, 32'hFFFF_FFFF);
        check("exc_busy",   32'(tif.busy), 32'd1);
        tick();
        check("exc_ev_once", 32'(tif.exception_event), 32'd0);
        check("exc_nodone",  32'(tif.trap_done), 32'd0);
        tif.exception_select = 1'b1;
        tick();
        tif.exception_select = 1'b0;
        check("exc_done",   32'(tif.trap_done), 32'd1);
        tick();
        check("exc_done1",  32'(tif.trap_done), 32'd0);
        check("exc_idle",   32'(tif.busy), 32'd0);
        check("exc_hold",   tif.cause, 32'd2);

        // Interrupt, all three pending, M-mode with MIE set -> MEI wins
        tif.mstatus       = 32'h8;
        tif.mie           = 32'h888;
        tif.mip           = 32'h888;
        tif.int_pc        = 32'h400;
        tif.insn_boundary = 1'b1;
        tick();
        tif.insn_boundary = 1'b0;
        check("int_event",  32'(tif.exception_event), 32'd1);
        check("int_cause",  tif.cause, 32'h8000_000B);
        check("int_pc",     tif.pc, 32'h400);
        check("int_bad",    tif.badaddr, 32'd0);
        check("int_wfi",    32'(tif.wfi_wakeup), 32'd1);
        tick();
        tif.exception_select = 1'b1;
        tick();
        tif.exception_select = 1'b0;
        check("int_done",   32'(tif.trap_done), 32'd1);
        tif.mip = 32'h0;
        tick();

        // Gating: MTI pending but M-mode with mstatus.MIE=0
        tif.mstatus       = 32'h0;
        tif.mie           = 32'h80;
        tif.mip           = 32'h80;
        tif.insn_boundary = 1'b1;
        tick();
        check("gate_event", 32'(tif.exception_event), 32'd0);
        check("gate_busy",  32'(tif.busy), 32'd0);
        check("gate_wfi",   32'(tif.wfi_wakeup), 32'd1);
        tif.privilege_mode = 2'd0;
        tick();
        tif.insn_boundary = 1'b0;
        check("umode_event", 32'(tif.exception_event), 32'd1);
        check("umode_cause", tif.cause, 32'h8000_0007);
        tick();
        tif.exception_select = 1'b1;
        tick();
        tif.exception_select = 1'b0;
        tick();

        // Simultaneous exception and eligible MTI: exception first, MTI afterwards
        tif.exc_valid     = 1'b1;
        tif.exc_cause     = 32'd8;
        tif.exc_pc        = 32'h0000_0200;
        tif.exc_badaddr   = 32'h0;
        tif.int_pc        = 32'h404;
        tif.insn_boundary = 1'b1;
        tick();
        tif.exc_valid = 1'b0;
        check("sim_cause",  tif.cause, 32'd8);
        check("sim_event",  32'(tif.exception_event), 32'd1);
        tick();
        check("sim_ignore", 32'(tif.exception_event), 32'd0);
        tif.exception_select = 1'b1;
        tick();
        tif.exception_select = 1'b0;
        check("sim_done",   32'(tif.trap_done), 32'd1);
        tick();
        check("sim_idle",   32'(tif.busy), 32'd0);
        tick();
        tif.insn_boundary = 1'b0;
        check("sim_int_ev", 32'(tif.exception_event), 32'd1);
        check("sim_int_c",  tif.cause, 32'h8000_0007);
        check("sim_int_pc", tif.pc, 32'h404);
        tif.mip = 32'h0;
        tick();
        tif.exception_select = 1'b1;
        tick();
        tif.exception_select = 1'b0;
        tick();

        // Redirect timeout
        tif.exc_valid   = 1'b1;
        tif.exc_cause   = 32'd5;
        tif.exc_pc      = 32'h100;
        tif.exc_badaddr = 32'h200;
        tick();
        tif.exc_valid = 1'b0;
        check("to_event",   32'(tif.exception_event), 32'd1);
        check("to_err0",    32'(tif.trap_error), 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("to_err_pre", 32'(tif.trap_error), 32'd0);
        check("to_done_pre", 32'(tif.trap_done), 32'd0);
        tick();
        check("to_err",     32'(tif.trap_error), 32'd1);
        check("to_done",    32'(tif.trap_done), 32'd1);
        tick();
        check("to_sticky",  32'(tif.trap_error), 32'd1);
        check("to_idle",    32'(tif.busy), 32'd0);
        tick();

        // Reset abort during WAIT_REDIR
        tif.exc_valid = 1'b1;
        tif.exc_cause = 32'd1;
        tick();
        tif.exc_valid = 1'b0;
        tick();
        check("ra_busy",    32'(tif.busy), 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("ra_idle",    32'(tif.busy), 32'd0);
        check("ra_nodone",  32'(tif.trap_done), 32'd0);
        check("ra_err",     32'(tif.trap_error), 32'd0);
        check("ra_cause",   tif.cause, 32'd0);
        tick();
        check("ra_nodone2", 32'(tif.trap_done), 32'd0);
        check("ra_busy2",   32'(tif.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
